operand_select_buffer: RTL

OPERAND_SELECT_BUFFER -- requirements
Module: operand_select_buffer

---
 rtl/operand_select_pkg.sv | 14 +
 rtl/operand_fifo.sv | 66 ++++++
 rtl/operand_select_buffer.sv | 68 ++++++
 3 files changed

// File: rtl/operand_select_pkg.sv
// Shared encodings for the operand select buffer.
// Selection codes and their width.
package operand_select_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_INPUT = 2'd0,
        SEL_ZERO  = 2'd1,
        SEL_ONE   = 2'd2,
        SEL_LAST  = 2'd3
    } sel_e;

endpackage

// File: rtl/operand_fifo.sv
// Small circular result buffer with push/pop and occupancy count.
// Head is presented combinationally and forced to zero when empty.
module operand_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/operand_select_buffer.sv
// Picks an operand source, remembers the last written value,
// and queues results for a valid/ready consumer.
module operand_select_buffer
    import operand_select_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] Input,
    input  logic [SEL_W-1:0] Selection,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Output,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CW-1:0]    Count
);

    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] w_sel_value;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    // Ready depends only on occupancy, never on the consumer.
    assign InReady  = !w_full;
    assign OutValid = !w_empty;
    assign w_accept = InValid && InReady;
    assign w_pop    = OutValid && OutReady;

    always_comb begin
        w_sel_value = Input;
        unique case (sel_e'(Selection))
            SEL_INPUT: w_sel_value = Input;
            SEL_ZERO:  w_sel_value = '0;
            SEL_ONE:   w_sel_value = WIDTH'(1);
            SEL_LAST:  w_sel_value = r_last;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_last <= '0;
        end else if (w_accept) begin
            r_last <= w_sel_value;
        end
    end

    operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (Clock),
        .i_rst_n   (ResetN),
        .i_push    (w_accept),
        .i_wr_data (w_sel_value),
        .i_pop     (w_pop),
        .o_rd_data (Output),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (Count)
    );

endmodule
